// File: rtl/fighter_action_sequencer.sv
`timescale 1ns/1ps
// Fighter action sequencer: punch/special/hitstun/cooldown action FSM with
// frame-accurate timing, clamped horizontal walk and a fixed-height jump timer.
module fighter_action_sequencer #(
  parameter int TICK_DIV        = 12_500_000,
  parameter int PUNCH_FRAMES    = 4,
  parameter int SP_FRAMES       = 4,
  parameter int HIT_FRAMES      = 3,
  parameter int COOLDOWN_FRAMES = 2,
  parameter int JUMP_FRAMES     = 6,
  parameter int X_INIT          = 24,
  parameter int X_MIN           = 8,
  parameter int X_MAX           = 88,
  parameter int X_STEP          = 2,
  parameter int Y_GROUND        = 32,
  parameter int JUMP_H          = 12
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_btn_left,
  input  logic       i_btn_right,
  input  logic       i_btn_up,
  input  logic       i_btn_attack,
  input  logic       i_sp_req,
  input  logic       i_hit,
  input  logic       i_facing_left,
  output logic [2:0] o_character_state,
  output logic [1:0] o_move_state,
  output logic       o_in_air,
  output logic       o_mirror,
  output logic [6:0] o_x,
  output logic [6:0] o_y,
  output logic       o_hit_window,
  output logic       o_busy
);

  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_PUNCH    = 3'd1;
  localparam logic [2:0] S_SPECIAL  = 3'd2;
  localparam logic [2:0] S_HITSTUN  = 3'd3;
  localparam logic [2:0] S_COOLDOWN = 3'd4;

  localparam logic [7:0] PUNCH_LAST = 8'(PUNCH_FRAMES - 1);
  localparam logic [7:0] SP_LAST    = 8'(SP_FRAMES - 1);
  localparam logic [7:0] HIT_LAST   = 8'(HIT_FRAMES - 1);
  localparam logic [7:0] CD_LAST    = 8'(COOLDOWN_FRAMES - 1);
  localparam logic [7:0] JUMP_LAST  = 8'(JUMP_FRAMES - 1);

  localparam logic [7:0] X_MIN8  = 8'(X_MIN);
  localparam logic [7:0] X_MAX8  = 8'(X_MAX);
  localparam logic [7:0] X_STEP8 = 8'(X_STEP);
  localparam logic [6:0] X_INIT7 = 7'(X_INIT);
  localparam logic [6:0] Y_GND7  = 7'(Y_GROUND);
  localparam logic [6:0] Y_AIR7  = 7'(Y_GROUND - JUMP_H);

  logic [2:0]    r_state;
  logic [DW-1:0] r_act_div;
  logic [7:0]    r_frame;
  logic          r_atk_prev;
  logic [2:0]    r_char_state;
  logic          r_hit_window;
  logic          r_busy;
  logic [DW-1:0] r_mv_div;
  logic [6:0]    r_x;
  logic [1:0]    r_move_state;
  logic          r_mirror;
  logic          r_in_air;
  logic [7:0]    r_jump_cnt;
  logic [6:0]    r_y;

  logic          w_atk_edge;
  logic          w_act_tick;
  logic          w_mv_tick;
  logic [2:0]    w_state_nxt;
  logic          w_restart;
  logic          w_enter;
  logic [DW-1:0] w_act_div_nxt;
  logic [7:0]    w_frame_nxt;
  logic [2:0]    w_char_nxt;
  logic [7:0]    w_x8;
  logic [7:0]    w_x_dec;
  logic [7:0]    w_x_inc;
  logic [6:0]    w_x_left;
  logic [6:0]    w_x_right;
  logic [6:0]    w_x_nxt;
  logic [1:0]    w_ms_nxt;
  logic          w_air_nxt;
  logic [7:0]    w_jcnt_nxt;

  // The attack history register resets high so a button already held at
  // reset release cannot count as a fresh press.
  assign w_atk_edge = i_btn_attack & ~r_atk_prev;
  assign w_act_tick = (r_act_div == DIV_LAST);
  assign w_mv_tick  = (r_mv_div == DIV_LAST);
  assign w_enter    = w_restart | (w_state_nxt != r_state);

  // Action FSM next state; hit pre-empts everything and restarts hitstun.
  always_comb begin
    w_state_nxt = r_state;
    w_restart   = 1'b0;
    if (i_hit) begin
      w_state_nxt = S_HITSTUN;
      w_restart   = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_sp_req) w_state_nxt = S_SPECIAL;
          else if (w_atk_edge) w_state_nxt = S_PUNCH;
          else w_state_nxt = S_IDLE;
        end
        S_PUNCH: begin
          if (w_act_tick && (r_frame == PUNCH_LAST)) w_state_nxt = S_COOLDOWN;
          else w_state_nxt = S_PUNCH;
        end
        S_SPECIAL: begin
          if (w_act_tick && (r_frame == SP_LAST)) w_state_nxt = S_COOLDOWN;
          else w_state_nxt = S_SPECIAL;
        end
        S_HITSTUN: begin
          if (w_act_tick && (r_frame == HIT_LAST)) w_state_nxt = S_IDLE;
          else w_state_nxt = S_HITSTUN;
        end
        S_COOLDOWN: begin
          if (w_act_tick && (r_frame == CD_LAST)) w_state_nxt = S_IDLE;
          else w_state_nxt = S_COOLDOWN;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Action divider and frame index, both cleared on every state entry.
  always_comb begin
    w_act_div_nxt = r_act_div;
    w_frame_nxt   = r_frame;
    if (w_enter || (w_state_nxt == S_IDLE)) begin
      w_act_div_nxt = {DW{1'b0}};
      w_frame_nxt   = 8'd0;
    end else if (w_act_tick) begin
      w_act_div_nxt = {DW{1'b0}};
      w_frame_nxt   = r_frame + 8'd1;
    end else begin
      w_act_div_nxt = r_act_div + {{(DW-1){1'b0}}, 1'b1};
      w_frame_nxt   = r_frame;
    end
  end

  // Character state encoding of the upcoming FSM state.
  always_comb begin
    case (w_state_nxt)
      S_PUNCH:   w_char_nxt = 3'b001;
      S_SPECIAL: w_char_nxt = 3'b010;
      S_HITSTUN: w_char_nxt = 3'b100;
      default:   w_char_nxt = 3'b000;
    endcase
  end

  // Action state, divider and the outputs derived from them.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_act_div    <= {DW{1'b0}};
      r_frame      <= 8'd0;
      r_atk_prev   <= 1'b1;
      r_char_state <= 3'b000;
      r_hit_window <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_act_div    <= w_act_div_nxt;
      r_frame      <= w_frame_nxt;
      r_atk_prev   <= i_btn_attack;
      r_char_state <= w_char_nxt;
      r_hit_window <= ((w_state_nxt == S_PUNCH) || (w_state_nxt == S_SPECIAL)) &&
                      (w_frame_nxt == 8'd2);
      r_busy       <= (w_state_nxt != S_IDLE);
    end
  end

  // Position math is widened to 8 bits so a step past either edge clamps instead of wrapping.
  assign w_x8      = {1'b0, r_x};
  assign w_x_dec   = w_x8 - X_STEP8;
  assign w_x_inc   = w_x8 + X_STEP8;
  assign w_x_left  = ((w_x8 < X_STEP8) || (w_x_dec < X_MIN8)) ? X_MIN8[6:0] : w_x_dec[6:0];
  assign w_x_right = (w_x_inc > X_MAX8) ? X_MAX8[6:0] : w_x_inc[6:0];

  // Walk direction and position, evaluated only on the move tick.
  always_comb begin
    w_x_nxt  = r_x;
    w_ms_nxt = r_move_state;
    if (w_mv_tick) begin
      w_ms_nxt = 2'b00;
      if ((r_state == S_IDLE) && i_btn_left && !i_btn_right) begin
        w_x_nxt  = w_x_left;
        w_ms_nxt = i_facing_left ? 2'b01 : 2'b10;
      end else if ((r_state == S_IDLE) && i_btn_right && !i_btn_left) begin
        w_x_nxt  = w_x_right;
        w_ms_nxt = i_facing_left ? 2'b10 : 2'b01;
      end else begin
        w_x_nxt  = r_x;
      end
    end else begin
      w_x_nxt  = r_x;
      w_ms_nxt = r_move_state;
    end
  end

  // Jump timer counts move ticks while airborne, independent of the action FSM.
  always_comb begin
    w_air_nxt  = r_in_air;
    w_jcnt_nxt = r_jump_cnt;
    if (w_mv_tick) begin
      if (!r_in_air && i_btn_up) begin
        w_air_nxt  = 1'b1;
        w_jcnt_nxt = 8'd0;
      end else if (r_in_air && (r_jump_cnt == JUMP_LAST)) begin
        w_air_nxt  = 1'b0;
        w_jcnt_nxt = 8'd0;
      end else if (r_in_air) begin
        w_jcnt_nxt = r_jump_cnt + 8'd1;
      end else begin
        w_jcnt_nxt = r_jump_cnt;
      end
    end else begin
      w_air_nxt  = r_in_air;
      w_jcnt_nxt = r_jump_cnt;
    end
  end

  // Movement, facing and jump registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mv_div     <= {DW{1'b0}};
      r_x          <= X_INIT7;
      r_move_state <= 2'b00;
      r_mirror     <= 1'b0;
      r_in_air     <= 1'b0;
      r_jump_cnt   <= 8'd0;
      r_y          <= Y_GND7;
    end else begin
      r_mv_div     <= w_mv_tick ? {DW{1'b0}} : (r_mv_div + {{(DW-1){1'b0}}, 1'b1});
      r_x          <= w_x_nxt;
      r_move_state <= w_ms_nxt;
      r_mirror     <= (r_state == S_IDLE) ? i_facing_left : r_mirror;
      r_in_air     <= w_air_nxt;
      r_jump_cnt   <= w_jcnt_nxt;
      r_y          <= w_air_nxt ? Y_AIR7 : Y_GND7;
    end
  end

  assign o_character_state = r_char_state;
  assign o_move_state      = r_move_state;
  assign o_in_air          = r_in_air;
  assign o_mirror          = r_mirror;
  assign o_x               = r_x;
  assign o_y               = r_y;
  assign o_hit_window      = r_hit_window;
  assign o_busy            = r_busy;

endmodule

// File: tb/tb_fighter_action_sequencer.sv
`timescale 1ns/1ps
// Scoreboard bench for fighter_action_sequencer: a timeline-level reference
// model predicts every cycle's outputs; a monitor compares them after each edge.
module tb_fighter_action_sequencer;

  localparam int TD = 4;
  localparam int N_PUNCH = 4, N_SP = 4, N_HIT = 3, N_CD = 2, N_JUMP = 6;
  localparam int XI = 24, XLO = 8, XHI = 88, XS = 2, YG = 32, JH = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_left = 1'b0, btn_right = 1'b0, btn_up = 1'b0, btn_attack = 1'b0;
  logic sp_req = 1'b0, hit = 1'b0, facing_left = 1'b0;
  logic [2:0] character_state;
  logic [1:0] move_state;
  logic in_air, mirror, hit_window, busy;
  logic [6:0] x, y;

  always #5 clk = ~clk;

  fighter_action_sequencer #(.TICK_DIV(TD)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_btn_left(btn_left), .i_btn_right(btn_right), .i_btn_up(btn_up),
    .i_btn_attack(btn_attack), .i_sp_req(sp_req), .i_hit(hit),
    .i_facing_left(facing_left),
    .o_character_state(character_state), .o_move_state(move_state),
    .o_in_air(in_air), .o_mirror(mirror), .o_x(x), .o_y(y),
    .o_hit_window(hit_window), .o_busy(busy)
  );

  typedef struct {
    int cs; int ms; int air; int mir; int xx; int yy; int hw; int bz;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail = 0;

  // Reference model: action kind, cycles spent in it and cycles left.
  int m_act, m_age, m_left, m_n, m_x, m_ms, m_mir, m_air, m_air_left;
  logic m_prev;

  task automatic check_val(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_act = 0; m_age = 0; m_left = 0; m_n = 0;
    m_x = XI; m_ms = 0; m_mir = 0; m_air = 0; m_air_left = 0;
    m_prev = 1'b1;
  endtask

  task automatic enter_action(input int a, input int frames);
    m_act = a; m_age = 0; m_left = frames * TD;
  endtask

  task automatic model_step(input logic l, input logic r, input logic u, input logic a,
                            input logic sp, input logic h, input logic fl);
    int cur;
    logic rise, mvt;
    m_n++;
    mvt = ((m_n % TD) == 0);
    cur = m_act;
    rise = a && !m_prev;
    m_prev = a;
    if (h) enter_action(3, N_HIT);
    else if (m_act == 0) begin
      if (sp) enter_action(2, N_SP);
      else if (rise) enter_action(1, N_PUNCH);
    end else begin
      m_age++;
      m_left--;
      if (m_left == 0) begin
        if (m_act == 1 || m_act == 2) enter_action(4, N_CD);
        else begin m_act = 0; m_age = 0; end
      end
    end
    if (mvt) begin
      if (cur == 0 && l && !r) begin
        m_x = (m_x - XS < XLO) ? XLO : m_x - XS;
        m_ms = fl ? 1 : 2;
      end else if (cur == 0 && r && !l) begin
        m_x = (m_x + XS > XHI) ? XHI : m_x + XS;
        m_ms = fl ? 2 : 1;
      end else m_ms = 0;
      if (!m_air && u) begin m_air = 1; m_air_left = N_JUMP; end
      else if (m_air) begin
        m_air_left--;
        if (m_air_left == 0) m_air = 0;
      end
    end
    if (cur == 0) m_mir = fl;
  endtask

  task automatic apply(input logic l, input logic r, input logic u, input logic a,
                       input logic sp, input logic h, input logic fl);
    exp_t e;
    btn_left = l; btn_right = r; btn_up = u; btn_attack = a;
    sp_req = sp; hit = h; facing_left = fl;
    model_step(l, r, u, a, sp, h, fl);
    e.cs  = (m_act == 1) ? 1 : (m_act == 2) ? 2 : (m_act == 3) ? 4 : 0;
    e.ms  = m_ms;
    e.air = m_air;
    e.mir = m_mir;
    e.xx  = m_x;
    e.yy  = m_air ? (YG - JH) : YG;
    e.hw  = ((m_act == 1 || m_act == 2) && (m_age / TD == 2)) ? 1 : 0;
    e.bz  = (m_act != 0) ? 1 : 0;
    sb.push_back(e);
  endtask

  task automatic drive(input logic l, input logic r, input logic u, input logic a,
                       input logic sp, input logic h, input logic fl);
    @(negedge clk);
    apply(l, r, u, a, sp, h, fl);
  endtask

  task automatic idle_cycles(input int n, input logic fl);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, fl);
  endtask

  // Asynchronous reset between edges; outputs must clear without a clock.
  task automatic do_reset(input logic atk_held);
    @(negedge clk);
    #2;
    btn_attack = atk_held;
    rst_n = 1'b0;
    #1;
    check_val("rst_char_state", character_state, 0);
    check_val("rst_move_state", move_state, 0);
    check_val("rst_in_air", in_air, 0);
    check_val("rst_mirror", mirror, 0);
    check_val("rst_x", x, XI);
    check_val("rst_y", y, YG);
    check_val("rst_hit_window", hit_window, 0);
    check_val("rst_busy", busy, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    apply(1'b0, 1'b0, 1'b0, atk_held, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: one expected record per clocked cycle, compared after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check_val("character_state", character_state, e.cs);
        check_val("move_state", move_state, e.ms);
        check_val("in_air", in_air, e.air);
        check_val("mirror", mirror, e.mir);
        check_val("x", x, e.xx);
        check_val("y", y, e.yy);
        check_val("hit_window", hit_window, e.hw);
        check_val("busy", busy, e.bz);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 2 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic l, r, u, a, fl;
    int seg, mode;
    model_reset();
    do_reset(1'b1);
    idle_cycles(3, 1'b0);

    // Punch: rise, then hold through cooldown back to idle.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle_cycles(2, 1'b0);

    // Special pre-empted by hit on its sixth cycle.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle_cycles(5, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle_cycles(16, 1'b0);

    // Collision of special request, attack rise and hit in one idle cycle.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    idle_cycles(16, 1'b1);

    // Walk to both clamps, facing left, then both buttons held.
    for (int i = 0; i < 180; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 360; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Jump, hit mid-air, then reset a few move ticks in.
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle_cycles(6, 1'b0);
    do_reset(1'b0);
    idle_cycles(4, 1'b0);

    // Randomised segments with sparse pulses and occasional resets.
    a = 1'b0;
    for (int s = 0; s < 40; s++) begin
      seg  = $urandom_range(20, 140);
      mode = $urandom_range(0, 3);
      fl   = 1'($urandom_range(0, 1));
      for (int i = 0; i < seg; i++) begin
        l = (mode == 1 || mode == 3);
        r = (mode == 2 || mode == 3);
        if ($urandom_range(0, 9) == 0) l = ~l;
        if ($urandom_range(0, 5) == 0) fl = ~fl;
        if ($urandom_range(0, 11) == 0) a = ~a;
        u = ($urandom_range(0, 9) == 0);
        drive(l, r, u, a, ($urandom_range(0, 50) == 0), ($urandom_range(0, 80) == 0), fl);
      end
      if ($urandom_range(0, 9) == 0) do_reset(1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    check_val("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fighter_action_sequencer.md
FIGHTER_ACTION_SEQUENCER -- requirements
Module: fighter_action_sequencer

Interface
REQ-001 SHALL have parameters (name, default, meaning): TICK_DIV, 12_500_000, clk cycles per animation frame (8 Hz at 100 MHz).
REQ-002 SHALL have parameters: PUNCH_FRAMES 4, SP_FRAMES 4, HIT_FRAMES 3, COOLDOWN_FRAMES 2, JUMP_FRAMES 6, frame counts per phase (each >=1).
REQ-003 SHALL have parameters: X_INIT 24, X_MIN 8, X_MAX 88, X_STEP 2, Y_GROUND 32, JUMP_H 12, position limits and steps.
REQ-004 SHALL have one clock and one reset: clk input 1, system clock; rst_n input 1, asynchronous active-low reset.
REQ-005 SHALL have ports: btn_left input 1; btn_right input 1; btn_up input 1; btn_attack input 1, level (already synchronised).
REQ-006 SHALL have ports: sp_req input 1, one-cycle special-move pulse; hit input 1, one-cycle damage pulse; facing_left input 1, opponent side.
REQ-007 SHALL have ports: character_state output 3; move_state output 2; in_air output 1; mirror output 1; x output 7; y output 7.
REQ-008 SHALL have ports: hit_window output 1, attack hitbox live; busy output 1, action in progress.

Function
REQ-009 Action FSM states: IDLE, PUNCH, SPECIAL, HITSTUN, COOLDOWN; character_state = 000, 001, 010, 100, 000 respectively.
REQ-010 Action divider: restarts at 0 on every FSM state entry, wraps at TICK_DIV-1, emitting act_tick; each action state lasts exactly its frame count x TICK_DIV cycles.
REQ-011 Move divider: free-running, independent of the action divider, emits mv_tick every TICK_DIV cycles.
REQ-012 Rising edge of btn_attack in IDLE -> PUNCH; state output changes on the next clk edge (1-cycle latency).
REQ-013 sp_req in IDLE -> SPECIAL; sp_req and attack edge in the same cycle -> SPECIAL.
REQ-014 hit in any state -> HITSTUN (restart if already HITSTUN); hit beats sp_req and attack in the same cycle.
REQ-015 PUNCH/SPECIAL end -> COOLDOWN; HITSTUN end -> IDLE; COOLDOWN end -> IDLE.
REQ-016 attack and sp_req outside IDLE are dropped, never queued.
REQ-017 busy = 1 in every state except IDLE.
REQ-018 hit_window = 1 only while in PUNCH or SPECIAL and frame index == 2 (third frame); frame index 0 on entry.
REQ-019 Horizontal move only in IDLE on mv_tick: exactly one of btn_left/btn_right held -> x -/+ X_STEP, saturating at X_MIN/X_MAX (never wraps).
REQ-020 move_state: 01 when the held direction points toward the opponent (left when facing_left=1, else right); 10 away; 00 for none, both, or non-IDLE.
REQ-021 move_state is registered and updates on mv_tick only.
REQ-022 mirror = facing_left, registered, updates only in IDLE (frozen during actions).
REQ-023 Jump: btn_up with in_air=0 on mv_tick -> in_air=1 for JUMP_FRAMES mv_ticks, then 0.
REQ-024 Jump is independent of the action FSM; hit does not cancel it.
REQ-025 y = Y_GROUND - JUMP_H while in_air, else Y_GROUND.
REQ-026 All arithmetic on x is done 8-bit before clamping so X_STEP underflow or overflow cannot wrap.

Reset
REQ-027 rst_n=0 immediately (asynchronously) forces IDLE, both dividers 0, character_state 000, move_state 00, in_air 0, mirror 0, x=X_INIT, y=Y_GROUND, hit_window 0, busy 0.
REQ-028 Reset mid-action or mid-jump aborts it with no residual state; the first attack edge is detected only from a low-to-high btn_attack transition sampled after reset release.

Verification (TICK_DIV=4)
REQ-029 Punch: attack rises in IDLE -> next edge character_state 001, busy 1.
REQ-030 Punch continued: hit_window high for cycles 8-11 after entry; COOLDOWN at cycle 16; IDLE at cycle 24.
REQ-031 Preempt: hit at cycle 5 of SPECIAL -> character_state 100 next edge, hit_window 0; IDLE 12 cycles later.
REQ-032 Collision: sp_req, attack edge and hit all in one IDLE cycle -> HITSTUN.
REQ-033 Clamp: x=87, btn_right held -> x=88 after one mv_tick and stays 88; x=9, btn_left -> 8.
REQ-034 Direction: facing_left=1, btn_left held -> move_state 01; both buttons held -> 00; during PUNCH -> 00 and x constant.
REQ-035 Jump + reset: btn_up -> in_air 1, y=20 for 6 mv_ticks; rst_n low at tick 3 -> in_air 0, y=32, x=24 immediately.
